seq_stage_ctrl: RTL
===================

Name: seq_stage_ctrl

Overview:
- Control sequencer for the sequential Y86-64 core.
- Owns the architectural PC and the processor status register.
- Steps the datapath through fetch, decode, execute, memory, writeback and PC-update, one stage-enable at a time.
- Consumes fetch-stage decode flags (icode, instr_valid, imem_error), the data-memory handshake, and the PC-select result; produces the PC driven into the fetch logic.

Parameters:
- PC_RESET, 64'd0, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin execution from IDLE.
- icode  in  4  instruction code from the fetch split logic.
- instr_valid  in  1  fetch reports a legal icode.
- imem_error  in  1  instruction fetch address out of range.
- mem_ready  in  1  data memory completes the current access.
- dmem_error  in  1  data memory address error; qualified by mem_ready.
- new_pc  in  64  next PC from PC-select logic (valP, valC or valM).
- pc  out  64  architectural PC, registered.
- fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en  out  1 each  stage enables, one-hot or all zero.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- busy  out  1  high in any state except IDLE and HALT.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, pc=PC_RESET, stat=1 (AOK), instr_count=0.
  - All enables 0, busy=0.
  - Reset mid-operation aborts immediately: nothing retires, no PC update.
- Enables are decoded from the registered state only; exactly one is high in states FETCH..PCUPD.
- IDLE: all enables 0. Go to FETCH on the clock edge where start=1.
- FETCH: fetch_en=1. Next-state priority at the edge:
  1. imem_error=1 → stat=ADR, go to HALT.
  2. instr_valid=0 → stat=INS, go to HALT.
  3. icode==4'h0 (halt) → stat=HLT, go to HALT.
  4. Otherwise go to DECODE.
- Fault or halt exits leave pc unchanged, pointing at the offending instruction.
- DECODE → EXECUTE → MEMORY: one cycle each.
- MEMORY: memory_en=1.
  - Held until mem_ready=1; no timeout.
  - When mem_ready=1 and dmem_error=1: stat=ADR, go to HALT. Writeback is skipped and pc is unchanged.
  - When mem_ready=1 and dmem_error=0: go to WRITEBACK.
  - dmem_error is ignored while mem_ready=0.
- WRITEBACK: one cycle, then PCUPD.
- PCUPD: pcupd_en=1. At the edge: pc<=new_pc, instr_count+=1 (wraps modulo 2^CNT_W), go to FETCH.
- HALT: all enables 0, busy=0; stat and pc frozen. start is ignored; only rst_n leaves HALT.
- Latency: 6 cycles per instruction with mem_ready=1 on the first MEMORY cycle, plus one cycle per wait cycle.
- The first fetch_en is asserted one cycle after start is sampled.
- No state ever asserts two enables. Unused state encodings recover to IDLE.

Test Plan:
- Reset, then pulse start with icode=4'h3, instr_valid=1, mem_ready=1, new_pc=10:
  - Enables step F,D,E,M,W,P across six cycles.
  - pc=10 and instr_count=1 after the PCUPD edge.
  - fetch_en rises again on the next cycle.
- Run three instructions with new_pc=10, 20, 22, then icode=0 at pc=22:
  - stat=2, pc=22, instr_count=3, busy=0.
  - State stays HALT after a further start pulse.
- Hold mem_ready=0 for 4 cycles in MEMORY:
  - memory_en stays high for 5 cycles.
  - A dmem_error=1 pulse during the wait has no effect; stat stays 1.
- In MEMORY assert mem_ready=1 and dmem_error=1 together:
  - stat=3, writeback_en never asserts, pc and instr_count unchanged.
- In FETCH assert imem_error=1 and instr_valid=0 together:
  - stat=3 (ADR wins over INS).
- Separately, instr_valid=0 alone gives stat=4.
- Drop rst_n while in EXECUTE:
  - Immediately pc=PC_RESET, stat=1, all enables 0, instr_count=0.
  - After release, nothing happens until start.

Source files
------------

// File: rtl/seq_stage_ctrl.sv
// rtl/seq_stage_ctrl.sv - stage sequencer, PC and status owner for the sequential Y86-64 core
module seq_stage_ctrl #(
  parameter logic [63:0] PC_RESET = 64'd0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             mem_ready,
  input  logic             dmem_error,
  input  logic [63:0]      new_pc,
  output logic [63:0]      pc,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             pcupd_en,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] ICODE_HALT = 4'h0;

  state_t           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, PC, status and retire counter; reset aborts any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RESET;
      stat_q  <= STAT_AOK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; faults and halt leave pc on the offending instruction
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (!instr_valid) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (icode == ICODE_HALT) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_MEMORY;
      S_MEMORY: begin
        // dmem_error only means something alongside mem_ready
        if (mem_ready) begin
          if (dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = S_HALT;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        pc_d    = new_pc;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage enables decoded purely from the registered state
  always_comb begin
    fetch_en     = 1'b0;
    decode_en    = 1'b0;
    execute_en   = 1'b0;
    memory_en    = 1'b0;
    writeback_en = 1'b0;
    pcupd_en     = 1'b0;
    busy         = 1'b1;
    case (state_q)
      S_FETCH:     fetch_en     = 1'b1;
      S_DECODE:    decode_en    = 1'b1;
      S_EXECUTE:   execute_en   = 1'b1;
      S_MEMORY:    memory_en    = 1'b1;
      S_WRITEBACK: writeback_en = 1'b1;
      S_PCUPD:     pcupd_en     = 1'b1;
      default:     busy         = 1'b0;
    endcase
  end

  assign pc          = pc_q;
  assign stat        = stat_q;
  assign instr_count = cnt_q;

endmodule
